// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage: shift-add multiply and restoring divide,
// one bit per cycle. The divider is only built when EX_MULDIV_DIV_EN is defined.
module ex_muldiv #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        rd_in,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        rd_out
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
`ifdef EX_MULDIV_DIV_EN
        StDiv  = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

    state_e                  state;
    logic [CntW-1:0]         cnt;
    logic [2*DATA_W-1:0]     acc;
    logic [DATA_W-1:0]       mag_b;
    logic [1:0]              op_q;
    logic [4:0]              rd_q;
    logic                    neg_q;

    // Operand conditioning at accept time
    logic              signed_a, signed_b, sa, sb;
    logic [DATA_W-1:0] mag_a, mag_b_in;

    always_comb begin
        signed_a = op[2] ? !op[0] : (op[1:0] != 2'b11);
        signed_b = op[2] ? !op[0] : !op[1];
        sa       = signed_a & a[DATA_W-1];
        sb       = signed_b & b[DATA_W-1];
        mag_a    = sa ? -a : a;
        mag_b_in = sb ? -b : b;
    end

    // Multiplier: acc = {partial high, remaining multiplier bits}
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next, mul_prod;
    logic [DATA_W-1:0]     mul_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mag_b};
        mul_next = acc[0] ? {mul_sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
        mul_prod = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == 2'b00) ? mul_prod[DATA_W-1:0] : mul_prod[2*DATA_W-1:DATA_W];
    end

`ifdef EX_MULDIV_DIV_EN
    logic              sa_q;
    logic [DATA_W:0]   rem_sh;
    logic              ge;
    logic [DATA_W-1:0] rem_new, quo, rem, div_res, special_res;
    logic              div_zero, div_ovf;

    // Divider: acc = {partial remainder, dividend bits shifting into quotient}
    always_comb begin
        rem_sh  = acc[2*DATA_W-1:DATA_W-1];
        ge      = rem_sh >= {1'b0, mag_b};
        rem_new = ge ? (rem_sh[DATA_W-1:0] - mag_b) : rem_sh[DATA_W-1:0];
        quo     = neg_q ? -{acc[DATA_W-2:0], ge} : {acc[DATA_W-2:0], ge};
        rem     = sa_q ? -rem_new : rem_new;
        div_res = op_q[1] ? rem : quo;

        div_zero    = (b == '0);
        div_ovf     = !op[0] && (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? a : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    assign busy = !rst && !flush &&
                  ((state == StIdle && start) || state == StMul || state == StDiv);
`else
    assign busy = !rst && !flush && ((state == StIdle && start) || state == StMul);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            cnt    <= '0;
            acc    <= '0;
            mag_b  <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
`ifdef EX_MULDIV_DIV_EN
            sa_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            op_q  <= op[1:0];
                            rd_q  <= rd_in;
                            neg_q <= sa ^ sb;
                            mag_b <= mag_b_in;
                            acc   <= {{DATA_W{1'b0}}, mag_a};
                            cnt   <= '0;
`ifdef EX_MULDIV_DIV_EN
                            sa_q  <= sa;
`endif
                            if (!op[2]) begin
                                state <= StMul;
                            end else begin
`ifdef EX_MULDIV_DIV_EN
                                if (div_zero || div_ovf) begin
                                    result <= special_res;
                                    rd_out <= rd_in;
                                    done   <= 1'b1;
                                    state  <= StDone;
                                end else begin
                                    state <= StDiv;
                                end
`else
                                result <= '0;
                                rd_out <= rd_in;
                                done   <= 1'b1;
                                state  <= StDone;
`endif
                            end
                        end
                    end
                    StMul: begin
                        acc <= mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CntLast) begin
                            result <= mul_res;
                            rd_out <= rd_q;
                            done   <= 1'b1;
                            state  <= StDone;
                        end
                    end
`ifdef EX_MULDIV_DIV_EN
                    StDiv: begin
                        acc <= {rem_new, acc[DATA_W-2:0], ge};
                        cnt <= cnt + 1'b1;
                        if (cnt == CntLast) begin
                            result <= div_res;
                            rd_out <= rd_q;
                            done   <= 1'b1;
                            state  <= StDone;
                        end
                    end
`endif
                    StDone:  state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected results are queued at issue and popped on done.
// Expectations for divide ops follow EX_MULDIV_DIV_EN.
module tb_ex_muldiv;

    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    ex_muldiv #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic [31:0]        r;
        r = '0;
        case (o)
            3'd0: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); r = sp[31:0]; end
            3'd1: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); r = sp[63:32]; end
            3'd2: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); r = sp[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; r = up[63:32]; end
            default: begin
`ifdef EX_MULDIV_DIV_EN
                if (y == 32'h0) r = o[1] ? x : 32'hFFFF_FFFF;
                else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    r = o[1] ? 32'h0 : 32'h8000_0000;
                else if (o == 3'd4) r = $signed(x) / $signed(y);
                else if (o == 3'd5) r = x / y;
                else if (o == 3'd6) r = $signed(x) % $signed(y);
                else r = x % y;
`else
                r = 32'h0;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
        if (!o[2]) return 33;
`ifdef EX_MULDIV_DIV_EN
        if (y == 32'h0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    // Called at a negedge; returns just after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input bit push);
        exp_t e;
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        #1 check("busy_accept", 32'(busy), 32'd1);
        if (push) begin
            e.res = model(o, x, y);
            e.rd  = r;
            e.lat = model_lat(o, x, y);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge of the cycle after done.
    task automatic wait_done();
        exp_t e;
        int   n = 0;
        int   bcnt = 0;
        bit   seen = 0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (busy) bcnt++;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("rd_out", 32'(rd_out), 32'(e.rd));
        check("latency", 32'(n), 32'(e.lat));
        check("busy_cycles", 32'(bcnt), 32'(e.lat - 1));
        check("busy_at_done", 32'(busy), 32'd0);
        last_res = e.res;
        last_rd  = e.rd;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    logic [2:0]  t_op [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd6, 3'd4, 3'd6, 3'd5};
    logic [31:0] t_a  [13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd55, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'd9};
    logic [31:0] t_b  [13] = '{32'hFFFF_FFFA, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

    initial begin
        int         dcnt;
        logic [2:0] rst_op;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 5'(i + 5), 1'b1);
            wait_done();
        end
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), $urandom, (i == 5) ? 32'h0 : $urandom, 5'($urandom_range(1, 31)), 1'b1);
            wait_done();
        end

        // Flush at T+10 of a MUL, then a fresh MUL at T+11.
        issue(3'd0, 32'd3, 32'd4, 5'd9, 1'b0);
        dcnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        flush = 1'b1;
        #1 check("flush_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_no_done", 32'(dcnt + 32'(done)), 32'd0);
        check("flush_hold_res", result, last_res);
        check("flush_hold_rd", 32'(rd_out), 32'(last_rd));
        issue(3'd0, 32'd11, 32'd13, 5'd17, 1'b1);
        wait_done();

        // flush together with start: nothing accepted.
        op = 3'd0; a = 32'd2; b = 32'd2; rd_in = 5'd3; start = 1'b1; flush = 1'b1;
        #1 check("flush_start_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("flush_start_idle", 32'(dcnt), 32'd0);

        // Asynchronous reset mid-operation.
`ifdef EX_MULDIV_DIV_EN
        rst_op = 3'd5;
`else
        rst_op = 3'd0;
`endif
        issue(rst_op, 32'd1000, 32'd3, 5'd21, 1'b0);
        for (int i = 1; i <= 20; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd30, 1'b1);
        wait_done();
        issue(3'd0, 32'd7, 32'hFFFF_FFFA, 5'd5, 1'b1);
        wait_done();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
